free_list: RTL and testbench
============================

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, RAM word width.
REQ-003 SHALL have parameter MAX_NODES, default 52, maximum nodes walked before abort (one full deck).
REQ-004 SHALL have port clock, input, 1, sole clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1, start request, sampled only in IDLE.
REQ-007 SHALL have port head_addr, input, ADDR_W, first node of the list to free; sampled with enable.
REQ-008 SHALL have port busy, output, 1, high from the cycle after accept until DONE is left.
REQ-009 SHALL have port done, output, 1, one-cycle pulse at completion.
REQ-010 SHALL have port error, output, 1, valid with done; set on abort, held until next accept.
REQ-011 SHALL have port freed_count, output, 6, nodes freed by the last operation; held until next accept.
REQ-012 SHALL have port ram_address, output, ADDR_W, RAM address.
REQ-013 SHALL have port ram_clock, output, 1, tied to clock.
REQ-014 SHALL have port ram_data, output, DATA_W, RAM write data.
REQ-015 SHALL have port ram_wren, output, 1, RAM write enable.
REQ-016 SHALL have port ram_q, input, DATA_W, RAM read data, valid one cycle after ram_address is presented.

Function
REQ-017 Node word SHALL be: [31] allocated flag, [15:14] suit, [13:10] value, [9:0] next address; address 0 is NULL.
REQ-018 FSM states SHALL be IDLE, READ, WAIT, CHECK, WRITE, DONE.
REQ-019 IDLE with enable=1: latch head_addr into cur, clear freed_count and error; head_addr=0 -> DONE, else -> READ.
REQ-020 READ: ram_address=cur, ram_wren=0; -> WAIT.
REQ-021 WAIT: hold ram_address; -> CHECK.
REQ-022 CHECK: ram_q[31]=0 (node not allocated) -> set error, -> DONE without writing; else latch next=ram_q[9:0], -> WRITE.
REQ-023 WRITE: ram_address=cur, ram_data=all zeros, ram_wren=1 for exactly one cycle; freed_count+1.
REQ-024 After WRITE: next=0 -> DONE; freed_count reached MAX_NODES with next!=0 -> set error, DONE (cycle/overlong guard); else cur=next, -> READ.
REQ-025 DONE: done=1 for one cycle, busy=0 thereafter; -> IDLE.
REQ-026 Latency SHALL be 4*N+2 cycles from enable-accept edge to done high for a clean N-node list; 2 cycles for head_addr=0.
REQ-027 enable while not IDLE SHALL be ignored; enable held high re-triggers only after DONE returns to IDLE.
REQ-028 ram_wren SHALL be 0 in every state other than WRITE.
REQ-029 Nodes freed before an abort SHALL remain freed; no rollback.

Reset
REQ-030 resetn=0 SHALL asynchronously force IDLE, ram_wren=0, ram_address=0, ram_data=0, busy=0, done=0, error=0, freed_count=0.
REQ-031 Reset mid-WRITE SHALL drop ram_wren immediately; partial list state is the caller's concern.

Structure
REQ-032 Node field positions, NULL_ADDR, ALLOC_BIT and MAX_NODES default SHALL live in shared package card_mem_pkg, also used by the allocator and list modules.
REQ-033 FSM state encoding SHALL be a typedef in card_mem_pkg.
REQ-034 No sub-module; single flat FSM plus datapath registers.

Verification
REQ-035 3-node list 5->9->12->0, all allocated, enable pulse -> three single-cycle writes of 0 to 5,9,12; done at cycle 14; freed_count=3; error=0.
REQ-036 head_addr=0 -> no ram_wren; done at cycle 2; freed_count=0; error=0.
REQ-037 list 5->9, node 9 has bit31=0 -> address 5 zeroed, 9 untouched; done with error=1, freed_count=1.
REQ-038 cyclic list 5->9->5 -> exactly 52 writes, then done with error=1, freed_count=52.
REQ-039 enable re-pulsed during operation -> ignored, result identical to REQ-035; resetn low during second WRITE -> ram_wren low same cycle, busy=0, state IDLE.

Source files
------------

// File: rtl/card_mem_pkg.sv
// Shared card-memory definitions: node word layout and list-walk states.
// Used by the allocator, list and free_list blocks.
package card_mem_pkg;

  localparam int ALLOC_BIT = 31;
  localparam int SUIT_MSB  = 15;
  localparam int SUIT_LSB  = 14;
  localparam int VAL_MSB   = 13;
  localparam int VAL_LSB   = 10;
  localparam int NEXT_MSB  = 9;
  localparam int NEXT_LSB  = 0;
  localparam int NEXT_W    = NEXT_MSB - NEXT_LSB + 1;

  localparam logic [NEXT_W-1:0] NULL_ADDR = '0;

  localparam int MAX_NODES_DEF = 52;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CHECK,
    S_WRITE,
    S_DONE
  } fl_state_t;

  function automatic logic [31:0] mk_node(
    input logic              alloc,
    input logic [1:0]        suit,
    input logic [3:0]        val,
    input logic [NEXT_W-1:0] nxt
  );
    logic [31:0] w;
    w = '0;
    w[ALLOC_BIT] = alloc;
    w[SUIT_MSB:SUIT_LSB] = suit;
    w[VAL_MSB:VAL_LSB] = val;
    w[NEXT_MSB:NEXT_LSB] = nxt;
    return w;
  endfunction

endpackage

// File: rtl/free_list.sv
// Walks a linked list in card RAM and zeroes every node,
// aborting on an unallocated node or an overlong/cyclic list.
module free_list
  import card_mem_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_NODES = MAX_NODES_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              enable,
  input  logic [ADDR_W-1:0] head_addr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [5:0]        freed_count,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_clock,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  fl_state_t         r_state;
  fl_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_cur;
  logic [ADDR_W-1:0] r_next;
  logic [5:0]        r_count;
  logic              r_error;
  logic              r_done;

  logic              w_alloc;
  logic [ADDR_W-1:0] w_q_next;
  logic [5:0]        w_count_inc;
  logic              w_next_null;
  logic              w_at_limit;
  logic              w_head_null;
  logic [DATA_W-1:0] w_unused_q;

  assign w_alloc     = ram_q[ALLOC_BIT];
  assign w_q_next    = ADDR_W'(ram_q[NEXT_MSB:NEXT_LSB]);
  assign w_count_inc = r_count + 6'd1;
  assign w_next_null = (r_next == '0);
  assign w_at_limit  = (w_count_inc == 6'(MAX_NODES));
  assign w_head_null = (head_addr == '0);
  assign w_unused_q  = ram_q;

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (enable)
          w_state_nxt = w_head_null ? S_DONE : S_READ;
      end
      S_READ:  w_state_nxt = S_WAIT;
      S_WAIT:  w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = w_alloc ? S_WRITE : S_DONE;
      S_WRITE: begin
        if (w_next_null || w_at_limit)
          w_state_nxt = S_DONE;
        else
          w_state_nxt = S_READ;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Walk datapath: current/next pointers, count, error, done pulse
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cur   <= '0;
      r_next  <= '0;
      r_count <= '0;
      r_error <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      unique case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_cur   <= head_addr;
            r_next  <= '0;
            r_count <= '0;
            r_error <= 1'b0;
          end
        end
        S_CHECK: begin
          if (!w_alloc) r_error <= 1'b1;
          else          r_next  <= w_q_next;
        end
        S_WRITE: begin
          r_count <= w_count_inc;
          if (!w_next_null) begin
            if (w_at_limit) r_error <= 1'b1;
            else            r_cur   <= r_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign error       = r_error;
  assign freed_count = r_count;
  assign ram_clock   = clock;
  assign ram_data    = '0;
  assign ram_wren    = (r_state == S_WRITE);
  assign ram_address = (r_state == S_READ  ||
                        r_state == S_WAIT  ||
                        r_state == S_CHECK ||
                        r_state == S_WRITE) ? r_cur : '0;

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: clean list, NULL head, unallocated
// node, cyclic list, ignored re-enable and reset during a write.
module tb_free_list;
  import card_mem_pkg::*;

  logic        clock;
  logic        resetn;
  logic        enable;
  logic [9:0]  head_addr;
  logic        busy;
  logic        done;
  logic        error;
  logic [5:0]  freed_count;
  logic [9:0]  ram_address;
  logic        ram_clock;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [0:1023];
  logic [9:0]  wr_addr_q [$];
  logic [31:0] wr_data_q [$];

  free_list #(.ADDR_W(10), .DATA_W(32), .MAX_NODES(52)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .enable      (enable),
    .head_addr   (head_addr),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .freed_count (freed_count),
    .ram_address (ram_address),
    .ram_clock   (ram_clock),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read RAM; DUT writes are captured, not applied.
  always @(posedge clock) begin
    ram_q <= mem[ram_address];
    if (ram_wren) begin
      wr_addr_q.push_back(ram_address);
      wr_data_q.push_back(ram_data);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Accept at one edge, then count edges until done is seen.
  task automatic run(input logic [9:0] head,
                     input bit repulse,
                     output int lat,
                     output logic busy0);
    lat = -1;
    busy0 = 1'bx;
    @(negedge clock);
    enable = 1'b1;
    head_addr = head;
    @(posedge clock);
    #1 enable = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      if (k == 0) busy0 = busy;
      if (done) begin
        lat = k + 1;
        break;
      end
      if (repulse && k == 3) begin
        enable = 1'b1;
        head_addr = 10'd7;
      end
      if (repulse && k == 6) enable = 1'b0;
      @(posedge clock);
    end
  endtask

  int          lat;
  logic        b0;
  int          base;
  logic [31:0] dor;

  initial begin
    resetn = 1'b0;
    enable = 1'b0;
    head_addr = '0;
    mem[0]  = 32'd0;
    mem[5]  = mk_node(1'b1, 2'd1, 4'd3, 10'd9);
    mem[9]  = mk_node(1'b1, 2'd2, 4'd7, 10'd12);
    mem[12] = mk_node(1'b1, 2'd3, 4'd12, 10'd0);
    mem[7]  = mk_node(1'b1, 2'd0, 4'd1, 10'd0);

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_freed", freed_count, 0);
    chk("rst_wren", ram_wren, 0);
    chk("rst_addr", ram_address, 0);
    chk("rst_data", ram_data, 0);
    @(negedge clock);
    resetn = 1'b1;

    // Clean 3-node list 5->9->12
    base = wr_addr_q.size();
    run(10'd5, 1'b0, lat, b0);
    chk("t1_busy_after_accept", b0, 1);
    chk("t1_latency", lat, 14);
    chk("t1_freed", freed_count, 3);
    chk("t1_error", error, 0);
    chk("t1_busy_at_done", busy, 0);
    chk("t1_nwrites", wr_addr_q.size() - base, 3);
    chk("t1_wr0", wr_addr_q[base], 5);
    chk("t1_wr1", wr_addr_q[base+1], 9);
    chk("t1_wr2", wr_addr_q[base+2], 12);
    dor = wr_data_q[base] | wr_data_q[base+1] | wr_data_q[base+2];
    chk("t1_wr_data_zero", dor, 0);
    @(negedge clock);
    chk("t1_done_one_cycle", done, 0);
    chk("t1_freed_held", freed_count, 3);

    // NULL head
    base = wr_addr_q.size();
    run(10'd0, 1'b0, lat, b0);
    chk("t2_latency", lat, 2);
    chk("t2_nwrites", wr_addr_q.size() - base, 0);
    chk("t2_freed", freed_count, 0);
    chk("t2_error", error, 0);

    // 5->9 with node 9 unallocated
    mem[9] = mk_node(1'b0, 2'd2, 4'd7, 10'd12);
    base = wr_addr_q.size();
    run(10'd5, 1'b0, lat, b0);
    chk("t3_latency", lat, 9);
    chk("t3_error", error, 1);
    chk("t3_freed", freed_count, 1);
    chk("t3_nwrites", wr_addr_q.size() - base, 1);
    chk("t3_wr0", wr_addr_q[base], 5);

    // Cyclic 5->9->5
    mem[9] = mk_node(1'b1, 2'd2, 4'd7, 10'd5);
    base = wr_addr_q.size();
    run(10'd5, 1'b0, lat, b0);
    chk("t4_latency", lat, 210);
    chk("t4_error", error, 1);
    chk("t4_freed", freed_count, 52);
    chk("t4_nwrites", wr_addr_q.size() - base, 52);
    chk("t4_wr_last", wr_addr_q[base+51], 9);

    // Re-enable during operation is ignored
    mem[9] = mk_node(1'b1, 2'd2, 4'd7, 10'd12);
    base = wr_addr_q.size();
    run(10'd5, 1'b1, lat, b0);
    chk("t5_latency", lat, 14);
    chk("t5_freed", freed_count, 3);
    chk("t5_error", error, 0);
    chk("t5_nwrites", wr_addr_q.size() - base, 3);
    chk("t5_wr2", wr_addr_q[base+2], 12);

    // Reset asserted during the second WRITE
    @(negedge clock);
    enable = 1'b1;
    head_addr = 10'd5;
    @(posedge clock);
    #1 enable = 1'b0;
    repeat (7) @(posedge clock);
    @(negedge clock);
    chk("t6_wren_before", ram_wren, 1);
    chk("t6_addr_before", ram_address, 9);
    resetn = 1'b0;
    #1;
    chk("t6_wren_reset", ram_wren, 0);
    chk("t6_busy_reset", busy, 0);
    chk("t6_state_reset", 32'(dut.r_state), 32'(S_IDLE));
    chk("t6_freed_reset", freed_count, 0);
    chk("t6_addr_reset", ram_address, 0);
    @(negedge clock);
    resetn = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
